spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_sync.sv | 29 ++
 rtl/spi_slave.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: register offsets, STATUS bit
// positions and the transfer state encoding.
package spi_slave_pkg;

  localparam logic [15:0] ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] ADDR_MODE   = 16'h0004;
  localparam logic [15:0] ADDR_STATUS = 16'h0008;
  localparam logic [15:0] ADDR_TXDATA = 16'h000C;
  localparam logic [15:0] ADDR_RXDATA = 16'h0010;
  localparam logic [15:0] ADDR_IE     = 16'h0014;

  localparam int STAT_RXV  = 0;
  localparam int STAT_TXE  = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_UDR  = 3;
  localparam int STAT_BUSY = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync #(
  parameter int   STAGES = 2,   // at least 2
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // sr[STAGES-1] is the synchronized level, sr[STAGES] its previous value.
  logic [STAGES:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= {(STAGES + 1){INIT}};
    else     sr <= {sr[STAGES-1:0], d};
  end

  assign q    = sr[STAGES-1];
  assign rise = sr[STAGES-1] & ~sr[STAGES];
  assign fall = ~sr[STAGES-1] & sr[STAGES];

endmodule

// File: rtl/spi_slave.sv
// SPI slave (modes 0-3, MSB first, 8-bit) with a small register interface,
// status flags and a level interrupt, all in the clk domain.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rw_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  state_e      state;
  logic        en, cpha, cpol;
  logic [3:0]  ie;
  logic        rxv, txe, ovr, udr;
  logic [7:0]  tx_data, rx_data, shreg;
  logic [2:0]  bit_cnt;
  logic [4:0]  status;

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(spi_sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_ok;
  assign unused_ok = ^{wr_data[31:8], sck_q, cs_q, mosi_rise, mosi_fall};

  // Bus decode
  logic wr_ok, wr_ctrl, wr_mode, wr_status, wr_tx, wr_ie, rd_rx;
  assign wr_ok     = wr_en && (wr_strb == 4'b1111);
  assign wr_ctrl   = wr_ok && (rw_addr == ADDR_CTRL);
  assign wr_mode   = wr_ok && (rw_addr == ADDR_MODE);
  assign wr_status = wr_ok && (rw_addr == ADDR_STATUS);
  assign wr_tx     = wr_ok && (rw_addr == ADDR_TXDATA);
  assign wr_ie     = wr_ok && (rw_addr == ADDR_IE);
  assign rd_rx     = rd_en && (rw_addr == ADDR_RXDATA);

  // Leading edge leaves the CPOL idle level; CPHA picks which edge samples.
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;

  logic       start, stop, byte_done, load;
  logic [7:0] load_byte, rx_byte;
  assign start     = (state == S_IDLE) && cs_fall && en;
  assign stop      = (state == S_SHIFT) && (cs_rise || !en);
  assign byte_done = (state == S_SHIFT) && !stop && sample_edge && (bit_cnt == 3'd7);
  assign load      = start || byte_done;
  assign load_byte = txe ? 8'hFF : tx_data;
  assign rx_byte   = {shreg[6:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_SHIFT;
            spi_miso_oe <= 1'b1;
            bit_cnt     <= '0;
            shreg       <= load_byte;
            spi_miso    <= load_byte[7];
          end
        end
        S_SHIFT: begin
          if (stop) begin
            state       <= S_IDLE;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b1;
            bit_cnt     <= '0;
          end else if (sample_edge) begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= byte_done ? load_byte : rx_byte;
            if (byte_done) spi_miso <= load_byte[7];
          end else if (shift_edge) begin
            spi_miso <= shreg[7];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file and flags; simultaneous set events take priority over clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      cpha    <= 1'b0;
      cpol    <= 1'b0;
      ie      <= '0;
      rxv     <= 1'b0;
      txe     <= 1'b1;
      ovr     <= 1'b0;
      udr     <= 1'b0;
      tx_data <= '0;
      rx_data <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) en <= wr_data[0];
      if (wr_mode && (state != S_SHIFT)) {cpol, cpha} <= wr_data[1:0];
      if (wr_ie) ie <= wr_data[3:0];
      if (wr_tx) tx_data <= wr_data[7:0];

      // A write coincident with a load keeps the new byte pending.
      if (wr_tx)              txe <= 1'b0;
      else if (load && !txe)  txe <= 1'b1;

      if (load && txe)                           udr <= 1'b1;
      else if (wr_status && wr_data[STAT_UDR])   udr <= 1'b0;

      if (byte_done && rxv && !rd_rx)            ovr <= 1'b1;
      else if (wr_status && wr_data[STAT_OVR])   ovr <= 1'b0;

      if (byte_done && (!rxv || rd_rx)) begin
        rx_data <= rx_byte;
        rxv     <= 1'b1;
      end else if (rd_rx) begin
        rxv     <= 1'b0;
      end

      irq <= |(status[3:0] & ie);
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    status            = '0;
    status[STAT_RXV]  = rxv;
    status[STAT_TXE]  = txe;
    status[STAT_OVR]  = ovr;
    status[STAT_UDR]  = udr;
    status[STAT_BUSY] = (state == S_SHIFT);
  end

  always_comb begin
    rd_data = '0;
    case (rw_addr)
      ADDR_CTRL:   rd_data[0]   = en;
      ADDR_MODE:   rd_data[1:0] = {cpol, cpha};
      ADDR_STATUS: rd_data[4:0] = status;
      ADDR_RXDATA: rd_data[7:0] = rx_data;
      ADDR_IE:     rd_data[3:0] = ie;
      default:     ;
    endcase
  end

endmodule
